// File: rtl/systolic_feeder_pkg.sv
// Shared types for the systolic array edge logic: element format, feeder
// states and the tokens that travel down the skew lines.
package tpu_pkg;

  localparam int DATA_WIDTH = 16;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SETTLE,
    STREAM,
    DRAIN
  } feeder_state_e;

  typedef struct packed {
    data_t data;
    logic  valid;
    logic  sw;
  } edge_token_t;

  // Columns carry no switch flag, so they use a narrower token.
  typedef struct packed {
    data_t data;
    logic  accept;
  } weight_token_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// Upstream weight-tile and input-vector streams (valid/ready) into the feeder.
interface systolic_feeder_if #(
  parameter int N = 2
) ();
  import tpu_pkg::*;

  logic [N*DATA_WIDTH-1:0] w_data;
  logic                    w_valid;
  logic                    w_ready;
  logic [N*DATA_WIDTH-1:0] x_data;
  logic                    x_valid;
  logic                    x_ready;

  modport master (
    output w_data, w_valid, x_data, x_valid,
    input  w_ready, x_ready
  );

  modport slave (
    input  w_data, w_valid, x_data, x_valid,
    output w_ready, x_ready
  );

endinterface

// File: rtl/systolic_feeder_skew.sv
// Token delay line: one capture register plus DEPTH further stages, so a token
// presented before edge k comes out in the cycle after edge k+DEPTH.
module skew_line
  import tpu_pkg::*;
#(
  parameter type token_t = edge_token_t,
  parameter int  DEPTH   = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  token_t d,
  output token_t q
);

  token_t stage [DEPTH+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i <= DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH];

endmodule

// File: rtl/systolic_feeder.sv
// Edge driver for the weight-stationary systolic array.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD_W | accepting N weight beats onto the column skew lines
//   SETTLE | 2N-1 cycles for the last weight to reach the bottom PE
//   STREAM | accepting num_vecs input vectors onto the row skew lines
//   DRAIN  | N cycles to empty the row skew lines, done in the last one
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int N          = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              num_vecs,
  systolic_feeder_if.slave        up,
  output logic [N*DATA_WIDTH-1:0] col_weight_out,
  output logic [N-1:0]            col_accept_w_out,
  output logic [N*DATA_WIDTH-1:0] row_input_out,
  output logic [N-1:0]            row_valid_out,
  output logic [N-1:0]            row_switch_out,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = $clog2(2*N);

  feeder_state_e state, state_n;
  logic [7:0]    beat_cnt, beat_n;
  logic [7:0]    nv_q, nv_n;
  logic [CW-1:0] phase_cnt, phase_n;
  logic          first_q, first_n;
  logic          w_rdy, x_rdy, w_acc, x_acc, sw_only;

  assign w_rdy      = (state == LOAD_W);
  assign x_rdy      = (state == STREAM) && (nv_q != 8'd0);
  assign up.w_ready = w_rdy;
  assign up.x_ready = x_rdy;
  assign w_acc      = w_rdy && up.w_valid;
  assign x_acc      = x_rdy && up.x_valid;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      nv_q      <= '0;
      phase_cnt <= '0;
      first_q   <= 1'b0;
    end else begin
      state     <= state_n;
      beat_cnt  <= beat_n;
      nv_q      <= nv_n;
      phase_cnt <= phase_n;
      first_q   <= first_n;
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat_cnt;
    nv_n    = nv_q;
    phase_n = phase_cnt;
    first_n = first_q;
    sw_only = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD_W;
          nv_n    = num_vecs;
          beat_n  = '0;
        end
      end
      LOAD_W: begin
        if (w_acc) begin
          beat_n = beat_cnt + 8'd1;
          if (beat_cnt == 8'(N - 1)) begin
            state_n = SETTLE;
            beat_n  = '0;
            phase_n = '0;
          end
        end
      end
      SETTLE: begin
        phase_n = phase_cnt + CW'(1);
        if (phase_cnt == CW'(2*N - 2)) begin
          state_n = STREAM;
          phase_n = '0;
          first_n = 1'b1;
        end
      end
      STREAM: begin
        // An empty job still has to flip the PEs to the new weights.
        if (nv_q == 8'd0) begin
          sw_only = 1'b1;
          first_n = 1'b0;
          state_n = DRAIN;
        end else if (x_acc) begin
          beat_n  = beat_cnt + 8'd1;
          first_n = 1'b0;
          if (beat_cnt == nv_q - 8'd1) state_n = DRAIN;
        end
      end
      DRAIN: begin
        phase_n = phase_cnt + CW'(1);
        if (phase_cnt == CW'(N - 1)) begin
          done    = 1'b1;
          state_n = IDLE;
          phase_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar c = 0; c < N; c++) begin : g_col
    weight_token_t tok, q;
    always_comb begin
      tok = '0;
      if (w_acc) begin
        tok.data   = up.w_data[c*DATA_WIDTH +: DATA_WIDTH];
        tok.accept = 1'b1;
      end
    end
    skew_line #(.token_t(weight_token_t), .DEPTH(c)) u_skew (
      .clk (clk),
      .rst (rst),
      .d   (tok),
      .q   (q)
    );
    assign col_weight_out[c*DATA_WIDTH +: DATA_WIDTH] = q.data;
    assign col_accept_w_out[c]                        = q.accept;
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    edge_token_t tok, q;
    always_comb begin
      tok = '0;
      if (x_acc) begin
        tok.data  = up.x_data[r*DATA_WIDTH +: DATA_WIDTH];
        tok.valid = 1'b1;
        tok.sw    = first_q;
      end
      if (sw_only) tok.sw = 1'b1;
    end
    skew_line #(.token_t(edge_token_t), .DEPTH(r)) u_skew (
      .clk (clk),
      .rst (rst),
      .d   (tok),
      .q   (q)
    );
    assign row_input_out[r*DATA_WIDTH +: DATA_WIDTH] = q.data;
    assign row_valid_out[r]                          = q.valid;
    assign row_switch_out[r]                         = q.sw;
  end

endmodule
